// File: rtl/byte_sum_packer.sv
// byte_sum_packer: packs LSB-first {carry,sum} bytes into NBYTES-wide words on a valid/ready output.
// Optional per-byte even parity on out_parity when BYTE_PACKER_PARITY_EN is defined.
module byte_sum_packer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8:0]            sum_in,
    input  logic                  sum_valid,
    input  logic                  sum_last,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   out_word,
    output logic                  out_carry,
    output logic                  out_short,
    output logic [NBYTES-1:0]     out_parity,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    typedef enum logic {IDLE, ACC} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [W-1:0]  acc, merged;
    logic          accept, full, complete;

    assign in_ready = !out_valid | out_ready;
    assign accept   = sum_valid & in_ready;
    assign full     = count == CW'(NBYTES - 1);
    assign complete = accept & (sum_last | full);
    // IDLE masks the accumulator so a fresh word never inherits stale bytes
    assign merged   = (state == IDLE ? '0 : acc) | (W'(sum_in[7:0]) << {count, 3'b000});

    always_comb begin
        state_nx = state;
        if (accept) state_nx = complete ? IDLE : ACC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_carry <= 1'b0;
            out_short <= 1'b0;
        end else begin
            state <= state_nx;
            if (out_valid & out_ready) out_valid <= 1'b0;
            if (accept) begin
                acc   <= complete ? '0 : merged;
                count <= complete ? '0 : count + CW'(1);
            end
            if (complete) begin
                out_valid <= 1'b1;
                out_word  <= merged;
                out_carry <= sum_in[8];
                out_short <= !full;
            end
        end
    end

`ifdef BYTE_PACKER_PARITY_EN
    logic [NBYTES-1:0] parity_nx;

    always_comb begin
        parity_nx = '0;
        for (int k = 0; k < NBYTES; k++) parity_nx[k] = ^merged[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) out_parity <= '0;
        else if (complete) out_parity <= parity_nx;
    end
`else
    assign out_parity = '0;
`endif
endmodule

// File: tb/tb_byte_sum_packer.sv
// tb_byte_sum_packer: randomized and directed checks of byte_sum_packer against a byte-queue model.
module tb_byte_sum_packer;
    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 0, rst = 1;
    logic [8:0]   sum_in = '0;
    logic         sum_valid = 0, sum_last = 0, out_ready = 0;
    logic         in_ready, out_carry, out_short, out_valid;
    logic [W-1:0] out_word;
    logic [N-1:0] out_parity;

    int total = 0, bad = 0;

    logic [8:0]   m_bytes[$];
    logic         m_valid = 0, m_carry = 0, m_short = 0;
    logic [W-1:0] m_word = '0;
    logic [N-1:0] m_par = '0;
    logic         ir, eir;

    byte_sum_packer #(.NBYTES(N)) dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .sum_last(sum_last),
        .in_ready(in_ready), .out_word(out_word), .out_carry(out_carry), .out_short(out_short),
        .out_parity(out_parity), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, predict the next outputs from the byte queue, advance past the edge.
    task automatic cycle(input logic r, input logic v, input logic [8:0] d, input logic l, input logic ordy);
        logic         nv, nc, ns;
        logic [W-1:0] nw;
        logic [N-1:0] np;
        rst = r; sum_valid = v; sum_in = d; sum_last = l; out_ready = ordy;
        #2;
        ir  = in_ready;
        eir = !m_valid || ordy;
        nv = m_valid && !ordy; nw = m_word; nc = m_carry; ns = m_short; np = m_par;
        if (r) begin
            nv = 0; nw = '0; nc = 0; ns = 0; np = '0;
            m_bytes.delete();
        end else if (v && eir) begin
            m_bytes.push_back(d);
            if (l || m_bytes.size() == N) begin
                nw = '0;
                np = '0;
                foreach (m_bytes[i]) begin
                    nw[8*i +: 8] = m_bytes[i][7:0];
`ifdef BYTE_PACKER_PARITY_EN
                    np[i] = ^m_bytes[i][7:0];
`endif
                end
                nc = d[8];
                ns = m_bytes.size() < N;
                nv = 1;
                m_bytes.delete();
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_word = nw; m_carry = nc; m_short = ns; m_par = np;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 9'h1FF, 1, 0);
            total++;
            if ({out_valid, out_word, out_carry, out_short, out_parity} !== '0) begin
                bad++;
                $display("FAIL reset: got v=%b w=%h c=%b s=%b p=%b, want all zero",
                         out_valid, out_word, out_carry, out_short, out_parity);
            end
        end
    endtask

    task automatic test_full_word();
        logic [8:0] seq[4] = '{9'h012, 9'h034, 9'h056, 9'h178};
        for (int i = 0; i < 4; i++) cycle(0, 1, seq[i], i == 3, 1);
        total++;
        if ({out_valid, out_word, out_carry, out_short} !== {1'b1, 32'h78563412, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL full_word: got v=%b w=%h c=%b s=%b, want v=1 w=78563412 c=1 s=0",
                     out_valid, out_word, out_carry, out_short);
        end
        cycle(0, 0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_word_drop: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_short();
        cycle(0, 1, 9'h0AA, 0, 1);
        cycle(0, 1, 9'h0BB, 1, 1);
        total++;
        if ({out_valid, out_word, out_carry, out_short} !== {1'b1, 32'h0000BBAA, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL short: got v=%b w=%h c=%b s=%b, want v=1 w=0000bbaa c=0 s=1",
                     out_valid, out_word, out_carry, out_short);
        end
        cycle(0, 1, 9'h1C3, 1, 1);
        total++;
        if ({out_valid, out_word, out_carry, out_short} !== {1'b1, 32'h000000C3, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL single_byte: got v=%b w=%h c=%b s=%b, want v=1 w=000000c3 c=1 s=1",
                     out_valid, out_word, out_carry, out_short);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_missing_last();
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 1, 9'(i), 0, 1);
            if (i == 4) begin
                total++;
                if ({out_valid, out_word, out_short} !== {1'b1, 32'h04030201, 1'b0}) begin
                    bad++;
                    $display("FAIL missing_last: got v=%b w=%h s=%b, want v=1 w=04030201 s=0",
                             out_valid, out_word, out_short);
                end
            end
        end
        cycle(0, 1, 9'h006, 1, 1);
        total++;
        if ({out_valid, out_word, out_short} !== {1'b1, 32'h00000605, 1'b1}) begin
            bad++;
            $display("FAIL carryover: got v=%b w=%h s=%b, want v=1 w=00000605 s=1",
                     out_valid, out_word, out_short);
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] held;
        for (int i = 0; i < 4; i++) cycle(0, 1, 9'h021 + 9'(i), 0, 1);
        held = {out_valid, out_word, out_carry, out_short};
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 9'h0EE, 1, 0);
            total++;
            if (ir !== 1'b0 || {out_valid, out_word, out_carry, out_short} !== held) begin
                bad++;
                $display("FAIL backpressure: got in_ready=%b out=%h, want in_ready=0 out=%h",
                         ir, {out_valid, out_word, out_carry, out_short}, held);
            end
        end
        for (int i = 0; i < 4; i++) cycle(0, 1, 9'h0D0 + 9'(i), i == 3, 1);
        total++;
        if ({out_valid, out_word, out_short} !== {1'b1, 32'hD3D2D1D0, 1'b0}) begin
            bad++;
            $display("FAIL after_backpressure: got v=%b w=%h s=%b, want v=1 w=d3d2d1d0 s=0",
                     out_valid, out_word, out_short);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] first;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 9'h040 + 9'(i), 0, 1);
            total++;
            if ({out_valid, out_word} !== {m_valid, m_word}) begin
                bad++;
                $display("FAIL b2b_stream: got v=%b w=%h, want v=%b w=%h", out_valid, out_word, m_valid, m_word);
            end
        end
        cycle(0, 1, 9'h011, 1, 1);
        first = out_word;
        cycle(0, 1, 9'h022, 1, 1);
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h00000022 || first !== 32'h00000011) begin
            bad++;
            $display("FAIL back_to_back: got v=%b w=%h prev=%h, want v=1 w=00000022 prev=00000011",
                     out_valid, out_word, first);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid_word();
        cycle(0, 1, 9'h0A1, 0, 1);
        cycle(0, 1, 9'h0A2, 0, 1);
        cycle(1, 0, 0, 0, 0);
        total++;
        if ({out_valid, out_word, out_carry, out_short, out_parity} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b w=%h, want zero", out_valid, out_word);
        end
        for (int i = 0; i < 4; i++) cycle(0, 1, 9'h0B1 + 9'(i), 0, 1);
        total++;
        if ({out_valid, out_word, out_short} !== {1'b1, 32'hB4B3B2B1, 1'b0}) begin
            bad++;
            $display("FAIL clean_word: got v=%b w=%h s=%b, want v=1 w=b4b3b2b1 s=0",
                     out_valid, out_word, out_short);
        end
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 9'h007, 0, 1);
        cycle(0, 1, 9'h003, 1, 1);
        total++;
`ifdef BYTE_PACKER_PARITY_EN
        if (out_parity !== 4'b0001) begin
            bad++;
            $display("FAIL parity: got %b, want 0001", out_parity);
        end
`else
        if (out_parity !== 4'b0000) begin
            bad++;
            $display("FAIL parity_off: got %b, want 0000", out_parity);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(i % 97 == 96, $urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0);
            total++;
            if (ir !== eir || {out_valid, out_word, out_carry, out_short, out_parity} !==
                {m_valid, m_word, m_carry, m_short, m_par}) begin
                bad++;
                $display("FAIL random[%0d]: got rdy=%b v=%b w=%h c=%b s=%b p=%b, want rdy=%b v=%b w=%h c=%b s=%b p=%b",
                         i, ir, out_valid, out_word, out_carry, out_short, out_parity,
                         eir, m_valid, m_word, m_carry, m_short, m_par);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short();
        test_missing_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
